// File: rtl/sort_oet_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sort_oet_seq
//  Brief    : Sequential odd-even transposition sorter, N keys in N phases,
//             valid/ready on both sides, run-time ascending/descending order.
//  Revision : 1.0 - initial release
// ============================================================================
module sort_oet_seq #(
    parameter  int WIDTH = 3,
    parameter  int N     = 8,
    localparam int CW    = $clog2(N*(N-1)/2+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               descend,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [CW-1:0]      swap_cnt,
    output logic               busy
);

    localparam int c_PW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_key     [N];
    logic [WIDTH-1:0] w_key_nxt [N];
    logic [c_PW-1:0]  r_phase;
    logic             r_desc;
    logic [CW-1:0]    r_swap;
    logic [CW-1:0]    w_swaps;
    logic             w_load;
    logic             w_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SORT;
                end
            end
            S_SORT: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_phase == c_PW'(N-1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...; pairs never
    // overlap, so every swap in a phase reads the same registered keys.
    always_comb begin
        w_key_nxt = r_key;
        w_swaps   = '0;
        for (int i = 0; i < N-1; i++) begin
            if ((i % 2) == int'(r_phase[0])) begin
                if (r_desc ? (r_key[i] < r_key[i+1]) : (r_key[i] > r_key[i+1])) begin
                    w_key_nxt[i]   = r_key[i+1];
                    w_key_nxt[i+1] = r_key[i];
                    w_swaps        = w_swaps + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_key[i] <= '0;
            end
            r_phase <= '0;
            r_desc  <= 1'b0;
            r_swap  <= '0;
        end else if (w_load) begin
            for (int i = 0; i < N; i++) begin
                r_key[i] <= in_data[i*WIDTH +: WIDTH];
            end
            r_phase <= '0;
            r_desc  <= descend;
            r_swap  <= '0;
        end else if (w_step) begin
            r_key   <= w_key_nxt;
            r_phase <= r_phase + c_PW'(1);
            r_swap  <= r_swap + w_swaps;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = r_key[g];
    end

    assign swap_cnt = r_swap;

endmodule
`default_nettype wire

// File: tb/tb_sort_oet_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sort_oet_seq
//  Brief    : Self-checking bench for sort_oet_seq (N=8 and N=3 instances)
//             against a bubble-sort / inversion-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sort_oet_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, in_ready8, descend8 = 1'b0;
    logic        out_valid8, out_ready8 = 1'b0, busy8;
    logic [23:0] in_data8 = '0, out_data8;
    logic [4:0]  swap_cnt8;

    logic        in_valid3 = 1'b0, in_ready3, descend3 = 1'b0;
    logic        out_valid3, out_ready3 = 1'b0, busy3;
    logic [8:0]  in_data3 = '0, out_data3;
    logic [1:0]  swap_cnt3;

    sort_oet_seq #(.WIDTH(3), .N(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .descend(descend8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .swap_cnt(swap_cnt8), .busy(busy8)
    );

    sort_oet_seq #(.WIDTH(3), .N(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .descend(descend3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .swap_cnt(swap_cnt3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sorted vector by plain bubble sort; swap count = number of inverted pairs.
    function automatic void ref_sort(input int n, input logic [23:0] vin, input logic d,
                                     output logic [23:0] vout, output int inv);
        int a[8];
        int t;
        for (int i = 0; i < n; i++) a[i] = int'(vin[i*3 +: 3]);
        inv = 0;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (d ? (a[i] < a[j]) : (a[i] > a[j])) inv++;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (d ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        vout = '0;
        for (int i = 0; i < n; i++) vout[i*3 +: 3] = 3'(a[i]);
    endfunction

    function automatic logic [23:0] pack8(input int k0, k1, k2, k3, k4, k5, k6, k7);
        int k[8] = '{k0, k1, k2, k3, k4, k5, k6, k7};
        logic [23:0] v = '0;
        for (int i = 0; i < 8; i++) v[i*3 +: 3] = 3'(k[i]);
        return v;
    endfunction

    // One vector through the N=8 instance; hold = cycles of backpressure in DONE.
    task automatic run8(input string tag, input logic [23:0] v, input logic d, input int hold);
        logic [23:0] ev;
        int          einv;
        int          t;
        ref_sort(8, v, d, ev, einv);
        t = 0;
        while (!in_ready8 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check({tag, " in_ready"}, 32'(in_ready8), 32'd1);
        in_valid8 = 1'b1; in_data8 = v; descend8 = d; out_ready8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0; in_data8 = 24'($urandom); descend8 = ~d;
        repeat (7) @(posedge clk);
        #1;
        check({tag, " early out_valid"}, 32'(out_valid8), 32'd0);
        check({tag, " busy"}, 32'(busy8), 32'd1);
        @(posedge clk); #1;
        check({tag, " out_valid"}, 32'(out_valid8), 32'd1);
        check({tag, " data"}, 32'(out_data8), 32'(ev));
        check({tag, " swap_cnt"}, 32'(swap_cnt8), 32'(einv));
        for (int h = 0; h < hold; h++) begin
            in_valid8 = 1'b1; in_data8 = 24'($urandom);
            @(posedge clk); #1;
            check({tag, " held data"}, 32'(out_data8), 32'(ev));
            check({tag, " held swap_cnt"}, 32'(swap_cnt8), 32'(einv));
            check({tag, " held in_ready"}, 32'(in_ready8), 32'd0);
            check({tag, " held out_valid"}, 32'(out_valid8), 32'd1);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check({tag, " released out_valid"}, 32'(out_valid8), 32'd0);
        check({tag, " released busy"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] exp_q[$];
        int          inv_q[$];
        logic [23:0] ev;
        int          einv;
        int          idx, got, cyc;
        logic        hs_in, hs_out;

        #2;
        check("reset out_valid", 32'(out_valid8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);
        check("reset swap_cnt", 32'(swap_cnt8), 32'd0);
        check("reset out_data", 32'(out_data8), 32'd0);
        check("reset in_ready", 32'(in_ready8), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        run8("asc 7..0", pack8(7, 6, 5, 4, 3, 2, 1, 0), 1'b0, 0);
        check("asc 7..0 swap const", 32'(swap_cnt8), 32'd28);
        run8("desc 0..7", pack8(0, 1, 2, 3, 4, 5, 6, 7), 1'b1, 0);
        run8("desc all5", pack8(5, 5, 5, 5, 5, 5, 5, 5), 1'b1, 0);
        run8("backpressure", 24'($urandom), 1'b0, 5);
        run8("after bp", 24'($urandom), 1'b1, 0);

        // Asynchronous reset in the middle of phase 3
        in_valid8 = 1'b1; in_data8 = pack8(7, 6, 5, 4, 3, 2, 1, 0); descend8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrun rst out_valid", 32'(out_valid8), 32'd0);
        check("midrun rst busy", 32'(busy8), 32'd0);
        check("midrun rst swap_cnt", 32'(swap_cnt8), 32'd0);
        check("midrun rst out_data", 32'(out_data8), 32'd0);
        check("midrun rst in_ready", 32'(in_ready8), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run8("post rst", pack8(3, 1, 2, 0, 7, 5, 6, 4), 1'b0, 0);

        for (int r = 0; r < 30; r++)
            run8("random8", 24'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        // N=3: every triple in both orders, back-to-back with random out_ready
        idx = 0; got = 0; cyc = 0;
        in_valid3 = 1'b1; in_data3 = 9'd0; descend3 = 1'b0;
        out_ready3 = 1'($urandom);
        while (got < 1024 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            hs_in  = in_valid3 && in_ready3;
            hs_out = out_valid3 && out_ready3;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    check("n3 unexpected output", 32'd1, 32'd0);
                end else begin
                    check("n3 data", 32'(out_data3), 32'(exp_q.pop_front()));
                    check("n3 swap_cnt", 32'(swap_cnt3), 32'(inv_q.pop_front()));
                end
                got++;
            end
            if (hs_in) begin
                ref_sort(3, {15'd0, in_data3}, descend3, ev, einv);
                exp_q.push_back(ev);
                inv_q.push_back(einv);
            end
            @(posedge clk); #1;
            if (hs_in) begin
                idx++;
                if (idx < 1024) begin
                    in_data3 = 9'(idx); descend3 = idx[9];
                end else begin
                    in_valid3 = 1'b0;
                end
            end
            out_ready3 = 1'($urandom);
        end
        check("n3 vectors completed", 32'(got), 32'd1024);
        in_valid3 = 1'b0; out_ready3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
